// File: rtl/mult_pkg.sv
// Shared constants for the shift-add sequential multiplier.
// Holds the state encoding and the default operand width.
package mult_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W     = $clog2(WIDTH_DEF) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/seq_mult_datapath.sv
// Datapath of the multiplier: operand registers, accumulator and counter.
// Performs one add-and-shift per Step and loads Product on LdP.
module seq_mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Init,
    input  logic               Step,
    input  logic               LdP,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               LastIter,
    output logic [2*WIDTH-1:0] Product
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH:0]     sum;

    always_comb begin
        // sum keeps the carry so it drops into the top bit after the shift
        sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (Init) begin
            mcand_d  = A;
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (Step) begin
            acc_d    = {sum, acc_q[WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
        end
        prod_d = LdP ? acc_d : prod_q;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            prod_q   <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
        end
    end

    assign LastIter = (cnt_q == LAST);
    assign Product  = prod_q;

endmodule

// File: rtl/seq_mult_8b.sv
// Unsigned shift-add sequential multiplier, one operand bit per cycle.
// Control FSM with registered Busy/Done/Ld outputs around the datapath.
module seq_mult_8b
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               Busy,
    output logic               Done,
    output logic               Ld,
    output logic [2*WIDTH-1:0] Product
);

    logic [1:0] state_q, state_d;
    logic       busy_q, done_q;
    logic       init, step, ldp, last_iter;

    assign init = (state_q == S_IDLE) && Start;
    assign step = (state_q == S_RUN);
    assign ldp  = step && last_iter;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs come straight from flops so the control unit sees no glitches
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

    seq_mult_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .Clk     (Clk),
        .Rst     (Rst),
        .Init    (init),
        .Step    (step),
        .LdP     (ldp),
        .A       (A),
        .B       (B),
        .LastIter(last_iter),
        .Product (Product)
    );

    assign Busy = busy_q;
    assign Done = done_q;
    assign Ld   = done_q;

endmodule

// File: tb/tb_seq_mult_8b.sv
// Scoreboard bench for seq_mult_8b: directed cases then random traffic.
// A cycle-level reference model predicts acceptance, Busy, Done and A*B.
module tb_seq_mult_8b;

    localparam int W = 8;

    logic           Clk = 1'b0;
    logic           Rst = 1'b0;
    logic           Start = 1'b0;
    logic [W-1:0]   A = '0;
    logic [W-1:0]   B = '0;
    logic           Busy, Done, Ld;
    logic [2*W-1:0] Product;

    int checks = 0;
    int passed = 0;
    int accepted = 0;
    int mcnt = 0;
    logic [2*W-1:0] exp_prod = '0;
    logic [2*W-1:0] sb[$];

    seq_mult_8b dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .Done   (Done),
        .Ld     (Ld),
        .Product(Product)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Reference model: idle unless inside the W+1 cycles after an accept
    always @(posedge Clk) begin
        if (Rst) begin
            if (mcnt != 0) mcnt = mcnt - 1;
            else if (Start) begin
                sb.push_back((2*W)'(A) * (2*W)'(B));
                mcnt = W + 1;
                accepted++;
            end
        end
    end

    always @(negedge Rst) begin
        sb.delete();
        mcnt = 0;
        exp_prod = '0;
    end

    always @(negedge Clk) begin
        chk("busy", 32'(Busy), 32'(mcnt != 0));
        chk("done", 32'(Done), 32'(mcnt == 1));
        chk("ld", 32'(Ld), 32'(mcnt == 1));
        if (Done) begin
            if (sb.size() == 0) chk("done_unexpected", 32'(Done), 32'd0);
            else exp_prod = sb.pop_front();
        end
        chk("product", 32'(Product), 32'(exp_prod));
    end

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge Clk); #2;
        Start = 1'b1; A = a; B = b;
        @(posedge Clk); #2;
        Start = 1'b0; A = W'($urandom); B = W'($urandom);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        @(negedge Clk);
        while ((mcnt != 0 || sb.size() != 0) && n < 200) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 200) chk(nm, 32'd1, 32'd0);
    endtask

    task automatic op_chk(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] p, input string nm);
        op(a, b);
        wait_idle({nm, "_timeout"});
        chk(nm, 32'(Product), 32'(p));
    endtask

    initial begin
        int n;
        int base;
        #13;
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_prod", 32'(Product), 32'd0);
        Rst = 1'b1;
        repeat (2) @(posedge Clk);

        op_chk(8'd13, 8'd11, 16'h008F, "p13x11");
        op_chk(8'd255, 8'd255, 16'hFE01, "p255x255");
        op_chk(8'd255, 8'd1, 16'h00FF, "p255x1");
        op_chk(8'd0, 8'd200, 16'h0000, "p0x200");

        // Start held high, operands changed while the first op runs
        base = accepted;
        @(posedge Clk); #2;
        Start = 1'b1; A = 8'd3; B = 8'd5;
        repeat (3) @(posedge Clk);
        #2; A = 8'd7; B = 8'd9;
        n = 0;
        while (accepted < base + 2 && n < 100) begin
            @(posedge Clk); n++;
        end
        #2; Start = 1'b0;
        chk("held_accepts", 32'(accepted - base), 32'd2);
        wait_idle("held_timeout");
        chk("held_p7x9", 32'(Product), 32'h003F);

        // Asynchronous reset in the middle of an operation
        op(8'd100, 8'd100);
        repeat (3) @(posedge Clk);
        #3; Rst = 1'b0;
        #1;
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_done", 32'(Done), 32'd0);
        chk("arst_prod", 32'(Product), 32'd0);
        repeat (2) @(posedge Clk);
        #3; Rst = 1'b1;
        op_chk(8'd2, 8'd2, 16'h0004, "p2x2");

        // Random traffic, Start also pulses while busy
        base = accepted;
        n = 0;
        while (accepted < base + 1000 && n < 40000) begin
            @(posedge Clk); #2;
            Start = ($urandom_range(0, 2) == 0);
            A = W'($urandom);
            B = W'($urandom);
            n++;
        end
        @(posedge Clk); #2;
        Start = 1'b0;
        chk("rand_ops", 32'(accepted - base >= 1000), 32'd1);
        wait_idle("rand_timeout");
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/seq_mult_8b.md
Name: seq_mult_8b

Overview:
- Unsigned shift-add sequential multiplier for the MiniComputer datapath.
- Accepts two WIDTH-bit operands on a Start strobe and iterates one bit per cycle.
- Presents a 2*WIDTH-bit product together with a one-cycle Ld strobe, so it can drive the Data/Ld pair of a downstream 16-bit load-enable register directly.
- Provides Busy/Done handshake for the control unit.

Parameters:
- WIDTH, 8, operand width in bits; product width is 2*WIDTH; iteration count is WIDTH.

Ports:
- Clk  input  1  system clock, all state changes on rising edge.
- Rst  input  1  reset, asynchronous, active-low (Rst=0 resets immediately, independent of Clk).
- Start  input  1  request a multiply; sampled only in IDLE.
- A  input  WIDTH  multiplicand, captured on accepted Start.
- B  input  WIDTH  multiplier, captured on accepted Start.
- Busy  output  1  high in RUN and DONE states.
- Done  output  1  one-cycle pulse, product valid.
- Ld  output  1  identical to Done; load strobe for downstream register.
- Product  output  2*WIDTH  result register; holds last result until next completion.

Behaviour:
- Reset (Rst=0, any state, including mid-operation):
  - State=IDLE.
  - Busy=0, Done=0, Ld=0, Product=0.
  - Internal accumulator, multiplicand, multiplier and counter all 0.
  - A pending operation is abandoned; no Done is produced for it.
- States: IDLE, RUN, DONE; binary encoding from the shared package.
- IDLE:
  - Start=1 at a rising edge: capture mcand<=A, mplier<=B, acc<=0, cnt<=0; go to RUN.
  - Start=0: remain in IDLE.
- RUN (one iteration per cycle):
  - If mplier[0]=1: upper half acc[2W-1:W] gets acc[2W-1:W]+mcand, computed WIDTH+1 bits wide so the carry is kept.
  - Then {carry, acc} shifts right 1; mplier shifts right 1; cnt+1.
  - When cnt reaches WIDTH-1 on this edge (final iteration): Product<=final acc; go to DONE.
- DONE: Done=Ld=1 for exactly this cycle; Busy=1; unconditionally go to IDLE.
- Latency:
  - Start sampled at the end of cycle 0.
  - RUN occupies cycles 1..WIDTH.
  - Done/Ld high in cycle WIDTH+1, which is cycle 9 for WIDTH=8.
  - Earliest next accepted Start is in cycle WIDTH+2, giving a throughput of one multiply per WIDTH+2 cycles.
- Start while Busy=1 (RUN or DONE): ignored, with no effect on the operation or the operands. A and B may change freely after capture.
- Product changes only on the final-iteration edge. It is stable during RUN and shows the previous result meanwhile.
- Arithmetic:
  - Unsigned only; no overflow is possible (2W-bit result).
  - 0 operand gives Product=0 after the full latency; there is no early exit.
  - Counter width is clog2(WIDTH)+1 bits, with no wrap inside one operation.
- Done and Ld are registered outputs (decoded from a state register), glitch-free.

Decomposition:
- Shared package mult_pkg:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - Default WIDTH=8 and derived CNT_W.
- One natural sub-module, seq_mult_datapath:
  - Contents: the mcand/mplier/acc/cnt registers, the adder and the shifter.
  - Controls (from the top-level FSM): Init (capture/clear), Step (iterate), LdP (load Product).
  - Status back to the FSM: LastIter.
- Top level holds the FSM and output decoding.

Test Plan:
- A=13, B=11, Start pulse in cycle 0 -> Busy=1 cycles 1-9; Done=Ld=1 only in cycle 9; Product=16'h008F (143) from cycle 9 on.
- A=255, B=255 -> Product=16'hFE01 in cycle 9; A=255, B=1 -> 16'h00FF; A=0, B=200 -> 16'h0000, still after 9 cycles.
- Start held high continuously with A=3, B=5 then A=7, B=9 changed mid-run -> first Done gives 16'h000F; second op accepted in cycle 10, giving Done in cycle 19 and 16'h003F.
- Rst driven low asynchronously in cycle 4 of A=100, B=100 -> immediately Busy=0, Product=0, no Done pulse; after release, Start with A=2, B=2 -> 16'h0004 after 9 cycles.
- Random unsigned A,B (>=1000 ops) with random Start gaps -> Product equals A*B; exactly one Done per accepted Start; Ld==Done every cycle.
